snake_game_sequencer: RTL
=========================

// Module: snake_game_sequencer
// PURPOSE
//  Game-flow controller for the 8x8 snake datapath. Owns the run state, the move-tick schedule and the
//  direction command. It issues a one-cycle move strobe plus the committed direction to the datapath and
//  counts score from datapath eat/collide pulses. Sits between board keys/switches and the snake datapath.
// PARAMETERS
//  TICK_BASE  4500000  SYS_CLK cycles between move ticks at score 0
//  TICK_STEP  250000   cycles removed from period per point (only with SNAKE_SPEEDUP_EN)
//  TICK_MIN   1000000  floor on the move period, cycles
//  WIN_SCORE  62       score that ends the game as WIN (max snake length 64)
// PORTS
//  SYS_CLK    in   1  system clock
//  RST        in   1  asynchronous, active-low reset
//  PAUSE      in   1  level; 1 = hold the game (asynchronous, synchronised internally)
//  UP         in   1  direction key, level (asynchronous)
//  DOWN       in   1  direction key, level (asynchronous)
//  LEFT       in   1  direction key, level (asynchronous)
//  RIGHT      in   1  direction key, level (asynchronous)
//  eat        in   1  one-cycle pulse from datapath: head reached item
//  collide    in   1  one-cycle pulse from datapath: head hit body
//  move_tick  out  1  one-cycle strobe: datapath advances one cell
//  move_dir   out  2  committed direction: 00 up, 01 down, 10 left, 11 right
//  clear      out  1  one-cycle strobe: datapath reloads initial snake/item
//  state      out  3  000 IDLE, 001 PLAY, 010 PAUSE, 011 OVER, 100 WIN
//  point      out  8  score, binary
// BEHAVIOUR
//  - Reset (RST=0, async): state=IDLE, move_dir=00, point=0, move_tick=0, clear=0, counter=0, pending=00.
//  - PAUSE and keys pass a 2-flop synchroniser; each key gets a rising-edge detector on the synced level.
//    Key-edge to internal effect: 3 cycles.
//  - Simultaneous key edges: priority UP > DOWN > LEFT > RIGHT.
//  - IDLE: any key edge -> clear=1 for one cycle, point=0, counter=0, move_dir=pending=that key, go PLAY.
//  - PLAY, counter: counts 0..period-1. At period-1: move_tick=1 for one cycle, move_dir<=pending, counter=0.
//    The first tick fires `period` cycles after entry to PLAY.
//  - PLAY, direction: a key edge sets pending only if the key is not the reverse of move_dir
//    (compare against the committed value, not pending). Multiple edges within one period: last accepted wins.
//  - eat (PLAY only): point<=point+1.
//    - If point+1==WIN_SCORE -> WIN on the next cycle.
//    - New period takes effect from the next counter wrap.
//  - collide (PLAY only): go OVER. collide and eat in the same cycle: collide wins, point unchanged.
//  - PLAY -> PAUSE when synced PAUSE=1: counter frozen, no ticks, eat/collide ignored, key edges still update pending.
//  - PAUSE -> PLAY when PAUSE=0: counting resumes from the held value.
//  - OVER/WIN: no ticks, point held, eat/collide ignored. A key edge with PAUSE=0 -> IDLE
//    (a second edge is needed to start).
//  - eat/collide in IDLE/PAUSE/OVER/WIN: ignored. point saturates at 255 (never wraps).
//  - move_tick and clear are never asserted in the same cycle. All outputs are registered.
//  - RST mid-game: immediate return to the reset values; no tick or clear is emitted on reset release.
// CONFIGURATION
//  SNAKE_SPEEDUP_EN defined: period = max(TICK_BASE - point*TICK_STEP, TICK_MIN), computed 32-bit
//    unsigned with the underflow clamped to TICK_MIN.
//  SNAKE_SPEEDUP_EN undefined: period = TICK_BASE constant; TICK_STEP and TICK_MIN unused.
// TESTING (bench params TICK_BASE=20, TICK_STEP=4, TICK_MIN=8, WIN_SCORE=3)
//  1. Reset, pulse UP -> clear 1 cycle, state=001, move_tick every 20 cycles, move_dir=00.
//  2. PLAY dir=00, edge DOWN then LEFT within one period -> DOWN rejected; next tick move_dir=10.
//  3. PAUSE=1 at counter=7 for 50 cycles -> no ticks, state=010; after release the next tick comes 13 cycles later (+sync).
//  4. Speedup on: eat x2 -> point=2, tick spacing 16 then 12. Speedup off: spacing stays 20.
//  5. eat with collide in the same cycle at point=1 -> state=011, point=1.
//     Then a key edge -> IDLE; a second key edge -> clear pulse, point=0.
//  6. eat x3 -> state=100, point=3, no further ticks. Drop RST mid-period -> all outputs at reset values.

Source files
------------

// File: rtl/snake_game_sequencer_if.sv
// Board/datapath side signals of the snake sequencer; master = sequencer, slave = keys + datapath.
// Latency: none (wiring only). Backpressure: none, all strobes are single-cycle and unacknowledged.
interface snake_game_sequencer_if;
    logic       PAUSE;
    logic       UP;
    logic       DOWN;
    logic       LEFT;
    logic       RIGHT;
    logic       eat;
    logic       collide;
    logic       move_tick;
    logic [1:0] move_dir;
    logic       clear;
    logic [2:0] state;
    logic [7:0] point;

    modport master (
        input  PAUSE, UP, DOWN, LEFT, RIGHT, eat, collide,
        output move_tick, move_dir, clear, state, point
    );

    modport slave (
        output PAUSE, UP, DOWN, LEFT, RIGHT, eat, collide,
        input  move_tick, move_dir, clear, state, point
    );
endinterface

// File: rtl/snake_game_sequencer.sv
// Snake game-flow controller: run state, move-tick schedule, direction and score (SNAKE_SPEEDUP_EN: score shortens tick period).
// Latency: key/PAUSE change to effect 3 cycles; eat/collide to point/state 1 cycle; all outputs registered.
// Backpressure: none; move_tick and clear are fire-and-forget one-cycle strobes.
module snake_game_sequencer #(
    parameter int unsigned TICK_BASE = 4500000,
    parameter int unsigned TICK_STEP = 250000,
    parameter int unsigned TICK_MIN  = 1000000,
    parameter int unsigned WIN_SCORE = 62
) (
    input  logic                   SYS_CLK,
    input  logic                   RST,
    snake_game_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_PLAY  = 3'b001,
        ST_PAUSE = 3'b010,
        ST_OVER  = 3'b011,
        ST_WIN   = 3'b100
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] period_calc;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  dir_q, dir_d;
    logic [7:0]  point_q, point_d;
    logic        tick_q, tick_d;
    logic        clear_q, clear_d;

    logic        pause_meta, pause_s;
    logic [3:0]  key_meta, key_s, key_prev;
    logic [3:0]  key_edge;
    logic        key_any;
    logic [1:0]  key_code;
    logic        key_ok;
    logic [7:0]  point_inc;
    logic        point_win;
    logic        advance;
    logic        won;

    // Key vector order: [0] UP, [1] DOWN, [2] LEFT, [3] RIGHT (matches the move_dir encodings).
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            pause_meta <= 1'b0;
            pause_s    <= 1'b0;
            key_meta   <= '0;
            key_s      <= '0;
            key_prev   <= '0;
        end else begin
            pause_meta <= bus.PAUSE;
            pause_s    <= pause_meta;
            key_meta   <= {bus.RIGHT, bus.LEFT, bus.DOWN, bus.UP};
            key_s      <= key_meta;
            key_prev   <= key_s;
        end
    end

    assign key_edge = key_s & ~key_prev;
    assign key_any  = |key_edge;

    always_comb begin
        key_code = 2'b11;
        if (key_edge[0])      key_code = 2'b00;
        else if (key_edge[1]) key_code = 2'b01;
        else if (key_edge[2]) key_code = 2'b10;
    end

    // Reversal is judged against the direction the snake is actually moving, not the pending one.
    assign key_ok    = key_any && (key_code != (dir_q ^ 2'b01));
    assign point_inc = (point_q == 8'hFF) ? point_q : point_q + 8'd1;
    assign point_win = (32'(point_inc) == WIN_SCORE);

`ifdef SNAKE_SPEEDUP_EN
    logic [31:0] speed_dec;
    assign speed_dec   = 32'(point_q) * TICK_STEP;
    assign period_calc = ((speed_dec >= TICK_BASE) || ((TICK_BASE - speed_dec) < TICK_MIN))
                         ? TICK_MIN : (TICK_BASE - speed_dec);
    localparam logic [31:0] PERIOD_START = (TICK_BASE < TICK_MIN) ? TICK_MIN : TICK_BASE;
`else
    assign period_calc = TICK_BASE;
    localparam logic [31:0] PERIOD_START = TICK_BASE;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pend_d   = pend_q;
        dir_d    = dir_q;
        point_d  = point_q;
        tick_d   = 1'b0;
        clear_d  = 1'b0;
        advance  = 1'b0;
        won      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_any) begin
                    clear_d  = 1'b1;
                    point_d  = '0;
                    cnt_d    = '0;
                    period_d = PERIOD_START;
                    dir_d    = key_code;
                    pend_d   = key_code;
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (key_ok) pend_d = key_code;
                if (bus.collide) begin
                    state_d = ST_OVER;
                end else begin
                    if (bus.eat) begin
                        point_d = point_inc;
                        won     = point_win;
                    end
                    if (won)          state_d = ST_WIN;
                    else if (pause_s) state_d = ST_PAUSE;
                    else              advance = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (key_ok) pend_d = key_code;
                // Resume counts on the release cycle so the pause costs exactly its synced length.
                if (!pause_s) begin
                    state_d = ST_PLAY;
                    advance = 1'b1;
                end
            end
            ST_OVER, ST_WIN: begin
                if (key_any && !pause_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Period is latched at the wrap, so a score change mid-period only shapes the next one.
        if (advance) begin
            if (cnt_q >= period_q - 32'd1) begin
                tick_d   = 1'b1;
                cnt_d    = '0;
                dir_d    = pend_d;
                period_d = period_calc;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= PERIOD_START;
            pend_q   <= 2'b00;
            dir_q    <= 2'b00;
            point_q  <= '0;
            tick_q   <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            point_q  <= point_d;
            tick_q   <= tick_d;
            clear_q  <= clear_d;
        end
    end

    assign bus.move_tick = tick_q;
    assign bus.move_dir  = dir_q;
    assign bus.clear     = clear_q;
    assign bus.state     = state_q;
    assign bus.point     = point_q;

    a_tick_clear_excl: assert property (@(posedge SYS_CLK) disable iff (!RST) !(tick_q && clear_q));
    a_no_tick_outside_play: assert property (@(posedge SYS_CLK) disable iff (!RST)
        tick_q |-> (state_q == ST_PLAY));

endmodule
